// File: rtl/dmem_arbiter.sv
// Data-memory front end: round-robin arbitration of the shared scalar/vector
// access path, per-access range checking with a sticky first-fault record,
// and the framebuffer scan-out sequencer on the memory's VGA read port.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 651,
  parameter int unsigned VGA_BASE  = 0,
  parameter int unsigned VGA_LEN   = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_req,
  input  logic        s_we,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic        s_gnt,
  output logic [31:0] s_rdata,
  input  logic        v_req,
  input  logic        v_we,
  input  logic [31:0] v_addr  [0:3],
  input  logic [31:0] v_wdata [0:3],
  output logic        v_gnt,
  output logic [31:0] v_rdata [0:3],
  output logic        m_we,
  output logic [31:0] m_a,
  output logic [31:0] m_wd,
  output logic        m_wev,
  output logic [31:0] m_va    [0:3],
  output logic [31:0] m_wdv   [0:3],
  output logic [31:0] m_avga,
  input  logic [31:0] m_rd,
  input  logic [31:0] m_rdv   [0:3],
  input  logic [31:0] m_rdvga,
  input  logic        vga_en,
  input  logic        vga_ready,
  output logic        vga_valid,
  output logic [7:0]  vga_pixel,
  output logic        frame_done,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
  localparam logic [31:0] PIX_BASE  = 32'(VGA_BASE);
  localparam logic [31:0] PIX_LAST  = 32'(VGA_LEN - 1);

  typedef enum logic {GNT_SCALAR, GNT_VECTOR} grant_t;
  typedef enum logic [1:0] {VGA_IDLE, VGA_LOAD, VGA_SHOW} vga_state_t;

  grant_t      last_grant_reg;
  vga_state_t  vga_state_reg;
  logic [31:0] cnt_reg;

  logic        s_pick;
  logic        v_pick;
  logic        s_ok;
  logic [3:0]  v_ok;
  logic        fault_hit;
  logic [31:0] fault_addr;

  // Only the low byte of the VGA read word carries the pixel.
  logic unused_vga_hi;
  assign unused_vga_hi = ^m_rdvga[31:8];

  // Round-robin pick: on contention the side that did not win last time wins.
  always_comb begin
    s_pick = s_req & (~v_req | (last_grant_reg == GNT_VECTOR));
    v_pick = v_req & ~s_pick;
  end

  // Reset masks both grants so nothing reaches memory in a reset cycle.
  assign s_gnt = s_pick & ~reset;
  assign v_gnt = v_pick & ~reset;

  assign s_ok    = (s_addr < MEM_LIMIT);
  assign m_a     = s_addr;
  assign m_wd    = s_wdata;
  assign m_we    = s_gnt & s_we & s_ok;
  assign s_rdata = (s_gnt & s_ok) ? m_rd : 32'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign v_ok[gi]    = (v_addr[gi] < MEM_LIMIT);
      assign m_va[gi]    = v_addr[gi];
      assign m_wdv[gi]   = v_wdata[gi];
      assign v_rdata[gi] = (v_gnt & v_ok[gi]) ? m_rdv[gi] : 32'd0;
    end
  endgenerate

  // A single faulting lane cancels the whole vector write.
  assign m_wev = v_gnt & v_we & (&v_ok);

  // Locate this cycle's fault; descending scan leaves the lowest faulting lane.
  always_comb begin
    fault_hit  = 1'b0;
    fault_addr = 32'd0;
    if (s_gnt && !s_ok) begin
      fault_hit  = 1'b1;
      fault_addr = s_addr;
    end
    if (v_gnt) begin
      for (int i = 3; i >= 0; i--) begin
        if (!v_ok[i]) begin
          fault_hit  = 1'b1;
          fault_addr = v_addr[i];
        end
      end
    end
  end

  // Remember which side was served last; scalar wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= GNT_VECTOR;
    end else if (s_gnt) begin
      last_grant_reg <= GNT_SCALAR;
    end else if (v_gnt) begin
      last_grant_reg <= GNT_VECTOR;
    end
  end

  // Sticky fault flag; only the first offending address is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      err      <= 1'b0;
      err_addr <= 32'd0;
    end else if (fault_hit && !err) begin
      err      <= 1'b1;
      err_addr <= fault_addr;
    end
  end

  assign m_avga = PIX_BASE + cnt_reg;

  // Scan-out sequencer: fetch a pixel in LOAD, present it in SHOW until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_state_reg <= VGA_IDLE;
      cnt_reg       <= 32'd0;
      vga_valid     <= 1'b0;
      vga_pixel     <= 8'd0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (vga_state_reg)
        VGA_IDLE: begin
          vga_valid <= 1'b0;
          if (vga_en) begin
            vga_state_reg <= VGA_LOAD;
          end
        end
        VGA_LOAD: begin
          vga_pixel <= m_rdvga[7:0];
          if (!vga_en) begin
            vga_state_reg <= VGA_IDLE;
            cnt_reg       <= 32'd0;
          end else begin
            vga_state_reg <= VGA_SHOW;
            vga_valid     <= 1'b1;
          end
        end
        VGA_SHOW: begin
          if (vga_ready) begin
            vga_valid <= 1'b0;
            if (cnt_reg == PIX_LAST) begin
              cnt_reg    <= 32'd0;
              frame_done <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 32'd1;
            end
            if (vga_en) begin
              vga_state_reg <= VGA_LOAD;
            end else begin
              vga_state_reg <= VGA_IDLE;
              cnt_reg       <= 32'd0;
            end
          end
        end
        default: begin
          vga_state_reg <= VGA_IDLE;
          vga_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule
